// File: rtl/hpdcache_pkg.sv
// HPDcache shared request, tag and PMA types.
// Used by the core request stage and its storage.
package hpdcache_pkg;

  typedef enum logic [3:0] {
    HPDCACHE_REQ_LOAD  = 4'h0,
    HPDCACHE_REQ_STORE = 4'h1,
    HPDCACHE_REQ_AMO   = 4'h2,
    HPDCACHE_REQ_CMO   = 4'h3
  } hpdcache_req_op_t;

  typedef logic [19:0] hpdcache_tag_t;

  typedef struct packed {
    logic uncacheable;
    logic io;
  } hpdcache_pma_t;

  typedef struct packed {
    logic [11:0]      addr_offset;
    logic [31:0]      wdata;
    hpdcache_req_op_t op;
    logic [3:0]       be;
    logic [1:0]       size;
    logic [2:0]       sid;
    logic [3:0]       tid;
  } hpdcache_req_t;

endpackage

// File: rtl/hpdcache_fifo_reg.sv
// Register-based FIFO with first-word-fall-through head.
// Entry storage is not reset; only pointers and count are.
module hpdcache_fifo_reg #(
  parameter int unsigned FIFO_DEPTH = 3,
  parameter type entry_t = logic
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             push_i,
  input  entry_t                           wdata_i,
  input  logic                             pop_i,
  output entry_t                           rdata_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  count_o
);

  localparam int unsigned PW =
    (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);

  entry_t        mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [CW-1:0] cnt_q;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) wptr_q <= inc(wptr_q);
      if (pop_i)  rptr_q <= inc(rptr_q);
      unique case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/hpdcache_core_req_stage.sv
// Core request stage: holds a request one cycle until tag/PMA/abort
// arrive, then queues the complete request for the controller.
module hpdcache_core_req_stage
  import hpdcache_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          in_req_valid_i,
  output logic          in_req_ready_o,
  input  hpdcache_req_t in_req_i,
  input  logic          in_abort_i,
  input  hpdcache_tag_t in_tag_i,
  input  hpdcache_pma_t in_pma_i,
  output logic          out_req_valid_o,
  input  logic          out_req_ready_i,
  output hpdcache_req_t out_req_o,
  output hpdcache_tag_t out_tag_o,
  output hpdcache_pma_t out_pma_o,
  output logic          abort_evt_o,
  output logic          empty_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    hpdcache_req_t req;
    hpdcache_tag_t tag;
    hpdcache_pma_t pma;
  } entry_t;

  logic          s1_valid_q;
  hpdcache_req_t s1_req_q;
  logic [CW-1:0] count;
  logic          accept;
  logic          push;
  logic          pop;
  entry_t        push_e;
  entry_t        head_e;

  // Stage-1 occupant reserves a slot so a push never meets a full FIFO
  assign in_req_ready_o =
    (32'(count) + 32'(s1_valid_q)) < FIFO_DEPTH;
  assign accept = in_req_valid_i & in_req_ready_o;
  assign push   = s1_valid_q & ~in_abort_i;
  assign abort_evt_o = s1_valid_q & in_abort_i;

  assign out_req_valid_o = (count != '0);
  assign pop     = out_req_valid_o & out_req_ready_i;
  assign empty_o = (count == '0) & ~s1_valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) s1_valid_q <= 1'b0;
    else         s1_valid_q <= accept;
  end

  always_ff @(posedge clk_i) begin
    if (accept) s1_req_q <= in_req_i;
  end

  assign push_e.req = s1_req_q;
  assign push_e.tag = in_tag_i;
  assign push_e.pma = in_pma_i;

  hpdcache_fifo_reg #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .entry_t    (entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i (push_e),
    .pop_i   (pop),
    .rdata_o (head_e),
    .count_o (count)
  );

  assign out_req_o = head_e.req;
  assign out_tag_o = head_e.tag;
  assign out_pma_o = head_e.pma;

endmodule

// File: tb/tb_hpdcache_core_req_stage.sv
// Bench for hpdcache_core_req_stage: queue model plus directed cases.
module tb_hpdcache_core_req_stage;
  import hpdcache_pkg::*;

  localparam int unsigned DEPTH = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_req_valid = 1'b0;
  logic          in_req_ready_o;
  hpdcache_req_t in_req = '0;
  logic          in_abort = 1'b0;
  hpdcache_tag_t in_tag = '0;
  hpdcache_pma_t in_pma = '0;
  logic          out_req_valid_o;
  logic          out_req_ready = 1'b0;
  hpdcache_req_t out_req_o;
  hpdcache_tag_t out_tag_o;
  hpdcache_pma_t out_pma_o;
  logic          abort_evt_o;
  logic          empty_o;

  always #5 clk = ~clk;

  hpdcache_core_req_stage #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .in_req_valid_i  (in_req_valid),
    .in_req_ready_o  (in_req_ready_o),
    .in_req_i        (in_req),
    .in_abort_i      (in_abort),
    .in_tag_i        (in_tag),
    .in_pma_i        (in_pma),
    .out_req_valid_o (out_req_valid_o),
    .out_req_ready_i (out_req_ready),
    .out_req_o       (out_req_o),
    .out_tag_o       (out_tag_o),
    .out_pma_o       (out_pma_o),
    .abort_evt_o     (abort_evt_o),
    .empty_o         (empty_o)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic hpdcache_req_t mk_req(input int i);
    hpdcache_req_t r;
    r.addr_offset = 12'(i * 4);
    r.wdata = 32'hCAFE_0000 | 32'(i);
    r.op = i[0] ? HPDCACHE_REQ_STORE : HPDCACHE_REQ_LOAD;
    r.be = 4'hF;
    r.size = 2'd2;
    r.sid = 3'd1;
    r.tid = 4'(i);
    return r;
  endfunction

  function automatic hpdcache_tag_t mk_tag(input int i);
    return 20'h100 + 20'(i);
  endfunction

  function automatic hpdcache_pma_t mk_pma(input int i);
    hpdcache_pma_t p;
    p.uncacheable = i[1];
    p.io = i[2];
    return p;
  endfunction

  // Model: one pending request awaiting tag, then an ordered queue
  typedef struct packed {
    hpdcache_req_t req;
    hpdcache_tag_t tag;
    hpdcache_pma_t pma;
  } ent_t;

  ent_t          mq[$];
  bit            m_pend = 0;
  hpdcache_req_t m_pend_req;
  hpdcache_tag_t pop_tags[$];
  int            pop_cyc[$];
  int            cyc = 0;
  int            abort_pulses = 0;
  bit            ready_dropped = 0;

  always @(posedge clk or negedge rst_n) begin
    bit acc;
    ent_t e;
    if (!rst_n) begin
      mq.delete();
      m_pend = 0;
    end else begin
      cyc++;
      acc = in_req_valid && ((mq.size() + int'(m_pend)) < DEPTH);
      if (m_pend && !in_abort)
        chk("push_not_full", 64'(mq.size() < DEPTH), 64'(1));
      if (mq.size() != 0 && out_req_ready) void'(mq.pop_front());
      if (m_pend && !in_abort) begin
        e.req = m_pend_req;
        e.tag = in_tag;
        e.pma = in_pma;
        mq.push_back(e);
      end
      m_pend = acc;
      if (acc) m_pend_req = in_req;
    end
  end

  always @(negedge clk) begin
    chk("in_req_ready", 64'(in_req_ready_o),
        64'((mq.size() + int'(m_pend)) < DEPTH));
    chk("out_req_valid", 64'(out_req_valid_o), 64'(mq.size() != 0));
    chk("empty", 64'(empty_o), 64'(mq.size() == 0 && !m_pend));
    chk("abort_evt", 64'(abort_evt_o), 64'(m_pend && in_abort));
    if (mq.size() != 0) begin
      chk("out_req", 64'(out_req_o), 64'(mq[0].req));
      chk("out_tag", 64'(out_tag_o), 64'(mq[0].tag));
      chk("out_pma", 64'(out_pma_o), 64'(mq[0].pma));
      if (out_req_ready) begin
        pop_tags.push_back(out_tag_o);
        pop_cyc.push_back(cyc);
      end
    end
    if (abort_evt_o) abort_pulses++;
    if (!in_req_ready_o) ready_dropped = 1;
  end

  task automatic step(input logic v, input hpdcache_req_t r,
                      input logic ab, input hpdcache_tag_t t,
                      input hpdcache_pma_t p);
    @(posedge clk);
    #1;
    in_req_valid = v;
    in_req = r;
    in_abort = ab;
    in_tag = t;
    in_pma = p;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic drain();
    int g = 0;
    while ((mq.size() != 0 || m_pend) && g < 50) begin
      idle(1);
      g++;
    end
    if (g >= 50) chk("drain_timeout", 64'(0), 64'(1));
    idle(1);
  endtask

  task automatic clear_logs();
    pop_tags.delete();
    pop_cyc.delete();
    abort_pulses = 0;
    ready_dropped = 0;
  endtask

  // Issue n requests back-to-back, tag/abort one cycle after acceptance
  task automatic stream(input int n, input int base,
                        input logic [15:0] amask);
    int i = 0;
    int pidx = 0;
    int guard = 0;
    bit acc_prev = 0;
    bit acc_now;
    while ((i < n || acc_prev) && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
      if (acc_prev) begin
        in_tag = mk_tag(base + pidx);
        in_pma = mk_pma(base + pidx);
        in_abort = amask[pidx];
      end else begin
        in_abort = 1'b0;
      end
      acc_now = 0;
      if (i < n) begin
        in_req_valid = 1'b1;
        in_req = mk_req(base + i);
        if (in_req_ready_o) begin
          acc_now = 1;
          pidx = i;
          i++;
        end
      end else begin
        in_req_valid = 1'b0;
      end
      acc_prev = acc_now;
    end
    if (guard >= 100) chk("stream_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    out_req_ready = 1'b1;
    #12;
    chk("rst_ready", 64'(in_req_ready_o), 64'(1));
    chk("rst_valid", 64'(out_req_valid_o), 64'(0));
    chk("rst_empty", 64'(empty_o), 64'(1));
    chk("rst_abort", 64'(abort_evt_o), 64'(0));
    rst_n = 1'b1;

    // single request, tag 0x1A
    step(1'b1, mk_req(160), 1'b0, '0, '0);
    step(1'b0, '0, 1'b0, 20'h1A, 2'b01);
    @(negedge clk);
    chk("single_t1_valid", 64'(out_req_valid_o), 64'(0));
    idle(1);
    @(negedge clk);
    chk("single_t2_valid", 64'(out_req_valid_o), 64'(1));
    chk("single_t2_tag", 64'(out_tag_o), 64'h1A);
    chk("single_t2_pma", 64'(out_pma_o), 64'(2'b01));
    chk("single_t2_req", 64'(out_req_o), 64'(mk_req(160)));
    idle(1);
    @(negedge clk);
    chk("single_t3_empty", 64'(empty_o), 64'(1));

    // abort of a single request
    step(1'b1, mk_req(161), 1'b0, '0, '0);
    step(1'b0, '0, 1'b1, 20'h55, '0);
    @(negedge clk);
    chk("abort_t1_evt", 64'(abort_evt_o), 64'(1));
    chk("abort_t1_valid", 64'(out_req_valid_o), 64'(0));
    idle(1);
    @(negedge clk);
    chk("abort_t2_empty", 64'(empty_o), 64'(1));
    chk("abort_t2_valid", 64'(out_req_valid_o), 64'(0));
    idle(3);

    // ten back-to-back with ready held
    clear_logs();
    stream(10, 0, 16'h0000);
    drain();
    chk("b2b_count", 64'(pop_tags.size()), 64'(10));
    for (int k = 0; k < 10 && k < pop_tags.size(); k++)
      chk("b2b_order", 64'(pop_tags[k]), 64'(20'h100 + 20'(k)));
    if (pop_cyc.size() == 10)
      chk("b2b_consec", 64'(pop_cyc[9] - pop_cyc[0]), 64'(9));
    chk("b2b_ready_held", 64'(ready_dropped), 64'(0));

    // backpressure fill and drain
    clear_logs();
    out_req_ready = 1'b0;
    stream(3, 16, 16'h0000);
    idle(1);
    @(negedge clk);
    chk("bp_full_ready", 64'(in_req_ready_o), 64'(0));
    chk("bp_full_head", 64'(out_tag_o), 64'h110);
    @(posedge clk);
    #1;
    out_req_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_still_low", 64'(in_req_ready_o), 64'(0));
    idle(1);
    @(negedge clk);
    chk("bp_ready_back", 64'(in_req_ready_o), 64'(1));
    drain();
    chk("bp_count", 64'(pop_tags.size()), 64'(3));
    if (pop_tags.size() == 3) begin
      chk("bp_o0", 64'(pop_tags[0]), 64'h110);
      chk("bp_o1", 64'(pop_tags[1]), 64'h111);
      chk("bp_o2", 64'(pop_tags[2]), 64'h112);
      chk("bp_consec", 64'(pop_cyc[2] - pop_cyc[0]), 64'(2));
    end

    // aborts on R1 and R3
    clear_logs();
    stream(6, 32, 16'b00_1010);
    drain();
    chk("ab_count", 64'(pop_tags.size()), 64'(4));
    if (pop_tags.size() == 4) begin
      chk("ab_o0", 64'(pop_tags[0]), 64'h120);
      chk("ab_o1", 64'(pop_tags[1]), 64'h122);
      chk("ab_o2", 64'(pop_tags[2]), 64'h124);
      chk("ab_o3", 64'(pop_tags[3]), 64'h125);
    end
    chk("ab_pulses", 64'(abort_pulses), 64'(2));

    // reset with two queued and stage 1 full
    out_req_ready = 1'b0;
    stream(2, 48, 16'h0000);
    step(1'b1, mk_req(50), 1'b0, mk_tag(49), mk_pma(49));
    @(posedge clk);
    #3;
    in_req_valid = 1'b0;
    chk("mid_pre_valid", 64'(out_req_valid_o), 64'(1));
    chk("mid_pre_empty", 64'(empty_o), 64'(0));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_req_valid_o), 64'(0));
    chk("mid_rst_empty", 64'(empty_o), 64'(1));
    chk("mid_rst_ready", 64'(in_req_ready_o), 64'(1));
    chk("mid_rst_abort", 64'(abort_evt_o), 64'(0));
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    clear_logs();
    out_req_ready = 1'b1;
    idle(5);
    chk("mid_no_stale", 64'(pop_tags.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hpdcache_core_req_stage.md
HPDCACHE_CORE_REQ_STAGE -- requirements
Module: hpdcache_core_req_stage

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 3, meaning number of complete-request slots (legal range 2..8).
REQ-002 SHALL have port clk_i  input  1  clock, all state updates on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_req_valid_i  input  1  granted request valid from the core arbiter.
REQ-005 SHALL have port in_req_ready_o  output  1  stage can accept a request this cycle.
REQ-006 SHALL have port in_req_i  input  $bits(hpdcache_req_t)  request payload, 1st cycle.
REQ-007 SHALL have port in_abort_i  input  1  abort for the request accepted in the previous cycle.
REQ-008 SHALL have port in_tag_i  input  $bits(hpdcache_tag_t)  tag for the request accepted in the previous cycle.
REQ-009 SHALL have port in_pma_i  input  $bits(hpdcache_pma_t)  PMA for the request accepted in the previous cycle.
REQ-010 SHALL have port out_req_valid_o  output  1  complete request available to the controller.
REQ-011 SHALL have port out_req_ready_i  input  1  controller consumes head request.
REQ-012 SHALL have ports out_req_o / out_tag_o / out_pma_o  output  hpdcache_req_t / hpdcache_tag_t / hpdcache_pma_t  head request fields.
REQ-013 SHALL have port abort_evt_o  output  1  pulse: request in stage 1 dropped due to abort.
REQ-014 SHALL have port empty_o  output  1  no request held in stage 1 or FIFO.

Function
REQ-015 SHALL accept a request when in_req_valid_i && in_req_ready_o, loading it into stage-1 register (s1_valid_q=1) at the next edge.
REQ-016 SHALL sample in_abort_i, in_tag_i, in_pma_i only in cycles where s1_valid_q=1; ignore them otherwise.
REQ-017 SHALL, when s1_valid_q=1 and in_abort_i=0, push {req,tag,pma} into the FIFO at that edge.
REQ-018 SHALL, when s1_valid_q=1 and in_abort_i=1, discard the stage-1 request and drive abort_evt_o=1 combinationally in that cycle.
REQ-019 SHALL allow stage-1 push/discard and a new acceptance in the same cycle (back-to-back, one per cycle).
REQ-020 SHALL drive in_req_ready_o = (count + s1_valid_q) < FIFO_DEPTH, from registered state only; no combinational path from out_req_ready_i.
REQ-021 SHALL present the FIFO head first-word-fall-through: out_req_valid_o = (count != 0).
REQ-022 SHALL pop the head when out_req_valid_o && out_req_ready_i; simultaneous push and pop leave count unchanged.
REQ-023 SHALL preserve acceptance order at the output; aborted requests leave no gap.
REQ-024 SHALL give minimum latency 2 cycles: accept at edge T, out_req_valid_o high after edge T+2.
REQ-025 SHALL sustain 1 request/cycle when FIFO_DEPTH>=3 and out_req_ready_i=1 continuously.
REQ-026 SHALL wrap read/write pointers modulo FIFO_DEPTH; count width $clog2(FIFO_DEPTH+1).
REQ-027 SHALL never push when full (guaranteed by REQ-020); bench asserts this.
REQ-028 SHALL drive empty_o = (count == 0) && !s1_valid_q.

Reset
REQ-029 SHALL on rst_ni=0 clear s1_valid_q, count, pointers immediately (asynchronous).
REQ-030 SHALL, during and after reset, drive out_req_valid_o=0, abort_evt_o=0, empty_o=1, in_req_ready_o=1; payload registers are not reset.
REQ-031 SHALL drop any in-flight stage-1 or FIFO requests on reset mid-operation with no output activity.

Structure
REQ-032 SHALL take hpdcache_req_t, hpdcache_tag_t, hpdcache_pma_t from hpdcache_pkg; no new package types.
REQ-033 SHALL implement storage with one sub-module hpdcache_fifo_reg (parameters FIFO_DEPTH, packed entry type); stage-1 register and ready logic in this module.

Verification
REQ-034 Single request A at T, tag 0x1A, abort 0, out_req_ready_i=1 -> out_req_valid_o at T+2, out_tag_o=0x1A, empty_o=1 at T+3.
REQ-035 Request at T, in_abort_i=1 at T+1 -> abort_evt_o=1 at T+1, no output valid ever, empty_o=1 at T+2.
REQ-036 Continuous requests R0..R9, out_req_ready_i=1, FIFO_DEPTH=3 -> in_req_ready_o stays 1, R0..R9 out in order on consecutive cycles.
REQ-037 out_req_ready_i=0, FIFO_DEPTH=3, push requests -> 3 accepted, in_req_ready_o=0 after (count+s1)=3; raise ready -> drains 3 in order, ready reasserts next cycle.
REQ-038 Alternate abort pattern on R0..R5 (abort R1,R3) -> outputs R0,R2,R4,R5 in order, abort_evt_o pulses twice.
REQ-039 Assert rst_ni=0 with 2 entries queued and stage 1 full -> out_req_valid_o=0 immediately, empty_o=1, in_req_ready_o=1; no stale request after release.
